rgb_to_yuv_encoder: RTL and testbench

RGB_TO_YUV_ENCODER -- requirements
Module: rgb_to_yuv_encoder

---
 rtl/rgb_to_yuv_encoder_pkg.sv | 39 +++
 rtl/rgb_to_yuv_csc.sv | 28 ++
 rtl/rgb_to_yuv_encoder.sv | 158 +++++++++++++++
 tb/tb_rgb_to_yuv_encoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_to_yuv_encoder_pkg.sv
// Shared definitions for the RGB<->YUV encoder/decoder pair: FSM state types,
// default SRAM region bases and colour-space-conversion coefficients.
package rgb_to_yuv_encoder_pkg;

  typedef enum logic [3:0] {
    S_E_IDLE, S_E_RD, S_E_WAIT, S_E_WR_Y0, S_E_WR_Y1, S_E_WR_U, S_E_WR_V, S_E_DONE
  } enc_state_e;

  typedef enum logic [3:0] {
    S_D_IDLE, S_D_RD_Y, S_D_RD_U, S_D_RD_V, S_D_WAIT, S_D_WR, S_D_DONE
  } dec_state_e;

  typedef enum logic [1:0] {CH_Y, CH_U, CH_V} csc_chan_e;

  typedef struct packed {
    int signed kr;
    int signed kg;
    int signed kb;
    int signed off;
  } csc_coef_t;

  localparam int unsigned DEF_RGB_BASE = 146944;
  localparam int unsigned DEF_Y_BASE   = 0;
  localparam int unsigned DEF_U_BASE   = 38400;
  localparam int unsigned DEF_V_BASE   = 57600;
  localparam int unsigned IMG_GROUPS   = 19200;
  localparam int signed   CSC_RND      = 128;

  function automatic csc_coef_t csc_coefs(input csc_chan_e ch);
    csc_coef_t c;
    case (ch)
      CH_U:    c = '{kr: -38, kg: -74, kb: 112, off: 128};
      CH_V:    c = '{kr: 112, kg: -94, kb: -18, off: 128};
      default: c = '{kr: 66,  kg: 129, kb: 25,  off: 16};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rgb_to_yuv_csc.sv
// One colour channel of one pixel per cycle: three multiplies, rounding sum,
// arithmetic shift, channel offset and clip to 8 bits.
module rgb_to_yuv_csc
  import rgb_to_yuv_encoder_pkg::*;
(
  input  csc_chan_e  chan_i,
  input  logic [7:0] r_i,
  input  logic [7:0] g_i,
  input  logic [7:0] b_i,
  output logic [7:0] c_o
);

  csc_coef_t          k;
  logic signed [31:0] prod_r, prod_g, prod_b, sum, scaled;

  always_comb begin
    k      = csc_coefs(chan_i);
    prod_r = k.kr * $signed({24'd0, r_i});
    prod_g = k.kg * $signed({24'd0, g_i});
    prod_b = k.kb * $signed({24'd0, b_i});
    sum    = prod_r + prod_g + prod_b + CSC_RND;
    scaled = (sum >>> 8) + k.off;
    if (scaled < 0)        c_o = '0;
    else if (scaled > 255) c_o = '1;
    else                   c_o = scaled[7:0];
  end

endmodule

// File: rtl/rgb_to_yuv_encoder.sv
// Converts an RGB image in SRAM to planar Y/U/V (U/V horizontally decimated),
// one 4-pixel group every 12 cycles through a single shared CSC datapath.
module rgb_to_yuv_encoder
  import rgb_to_yuv_encoder_pkg::*;
#(
  parameter int unsigned RGB_BASE   = DEF_RGB_BASE,
  parameter int unsigned Y_BASE     = DEF_Y_BASE,
  parameter int unsigned U_BASE     = DEF_U_BASE,
  parameter int unsigned V_BASE     = DEF_V_BASE,
  parameter int unsigned NUM_GROUPS = IMG_GROUPS
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Enable,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Done
);

  enc_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [14:0] grp_q, grp_d;
  logic [17:0] addr_q, addr_d, six_k;
  logic [15:0] wdata_q, wdata_d;
  logic        we_n_q, we_n_d, done_q, done_d;
  logic [15:0] w_q [6];
  logic [7:0]  y0_q, y1_q, y2_q, u0_q, v0_q;
  csc_chan_e   chan;
  logic [7:0]  op_r, op_g, op_b, csc_res;

  rgb_to_yuv_csc u_csc (
    .chan_i (chan),
    .r_i    (op_r),
    .g_i    (op_g),
    .b_i    (op_b),
    .c_o    (csc_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grp_d   = grp_q;
    case (state_q)
      S_E_IDLE: if (Enable) begin
        state_d = S_E_RD;
        cnt_d   = '0;
        grp_d   = '0;
      end
      S_E_RD: if (cnt_q == 3'd5) begin
        state_d = S_E_WAIT;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 3'd1;
      S_E_WAIT: if (cnt_q == 3'd1) begin
        state_d = S_E_WR_Y0;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 3'd1;
      S_E_WR_Y0: state_d = S_E_WR_Y1;
      S_E_WR_Y1: state_d = S_E_WR_U;
      S_E_WR_U:  state_d = S_E_WR_V;
      S_E_WR_V: if (grp_q == 15'(NUM_GROUPS - 1)) state_d = S_E_DONE;
      else begin
        state_d = S_E_RD;
        grp_d   = grp_q + 15'd1;
      end
      default: state_d = S_E_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next state.
  always_comb begin
    six_k  = 18'({grp_d, 2'b00}) + 18'({grp_d, 1'b0});
    case (state_d)
      S_E_RD:    addr_d = 18'(RGB_BASE) + six_k + 18'(cnt_d);
      S_E_WR_Y0: addr_d = 18'(Y_BASE) + 18'({grp_d, 1'b0});
      S_E_WR_Y1: addr_d = 18'(Y_BASE) + 18'({grp_d, 1'b0}) + 18'd1;
      S_E_WR_U:  addr_d = 18'(U_BASE) + 18'(grp_d);
      S_E_WR_V:  addr_d = 18'(V_BASE) + 18'(grp_d);
      default:   addr_d = '0;
    endcase
    we_n_d  = !(state_d inside {S_E_WR_Y0, S_E_WR_Y1, S_E_WR_U, S_E_WR_V});
    done_d  = (state_d == S_E_DONE);
    wdata_d = '0;
    case (state_q)
      S_E_WAIT:  if (cnt_q == 3'd1) wdata_d = {y0_q, y1_q};
      S_E_WR_Y0: wdata_d = {y2_q, csc_res};
      S_E_WR_Y1: wdata_d = {u0_q, csc_res};
      S_E_WR_U:  wdata_d = {v0_q, csc_res};
      default:   wdata_d = '0;
    endcase
  end

  // Eight CSC slots per group; Y0 takes B0 straight off the read bus so that
  // all eight fit before the last write needs its data.
  always_comb begin
    chan = CH_Y;
    op_r = '0;
    op_g = '0;
    op_b = '0;
    case (state_q)
      S_E_RD: case (cnt_q)
        3'd3: begin {op_r, op_g} = w_q[0]; op_b = SRAM_read_data[15:8]; end
        3'd4: begin {op_r, op_g} = w_q[0]; op_b = w_q[1][15:8]; chan = CH_U; end
        3'd5: begin {op_r, op_g} = w_q[0]; op_b = w_q[1][15:8]; chan = CH_V; end
        default: ;
      endcase
      S_E_WAIT: if (cnt_q == 3'd0) begin
        op_r = w_q[1][7:0]; {op_g, op_b} = w_q[2];
      end else begin
        {op_r, op_g} = w_q[3]; op_b = w_q[4][15:8];
      end
      S_E_WR_Y0: begin op_r = w_q[4][7:0]; {op_g, op_b} = w_q[5]; end
      S_E_WR_Y1: begin {op_r, op_g} = w_q[3]; op_b = w_q[4][15:8]; chan = CH_U; end
      S_E_WR_U:  begin {op_r, op_g} = w_q[3]; op_b = w_q[4][15:8]; chan = CH_V; end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_E_IDLE;
      cnt_q   <= '0;
      grp_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_n_q  <= 1'b1;
      done_q  <= 1'b0;
      y0_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      u0_q    <= '0;
      v0_q    <= '0;
      for (int unsigned i = 0; i < 6; i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grp_q   <= grp_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_n_q  <= we_n_d;
      done_q  <= done_d;
      if (state_q == S_E_RD && cnt_q >= 3'd2) w_q[cnt_q - 3'd2] <= SRAM_read_data;
      if (state_q == S_E_WAIT) w_q[3'd4 + cnt_q] <= SRAM_read_data;
      if (state_q == S_E_RD && cnt_q == 3'd3) y0_q <= csc_res;
      if (state_q == S_E_RD && cnt_q == 3'd4) u0_q <= csc_res;
      if (state_q == S_E_RD && cnt_q == 3'd5) v0_q <= csc_res;
      if (state_q == S_E_WAIT && cnt_q == 3'd0) y1_q <= csc_res;
      if (state_q == S_E_WAIT && cnt_q == 3'd1) y2_q <= csc_res;
    end
  end

  assign SRAM_address    = addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n       = we_n_q;
  assign Done            = done_q;

endmodule

// File: tb/tb_rgb_to_yuv_encoder.sv
// Bench for rgb_to_yuv_encoder with a reduced group count: SRAM model with
// 2-cycle read latency, behavioural YUV model and a per-write compare process.
module tb_rgb_to_yuv_encoder;

  localparam int NG    = 64;
  localparam int NPIX  = NG * 4;
  localparam int RGB_B = 146944;
  localparam int Y_B   = 0;
  localparam int U_B   = 38400;
  localparam int V_B   = 57600;

  logic        Clock = 1'b0;
  logic        Resetn, Enable;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data = '0;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n, Done;

  rgb_to_yuv_encoder #(
    .RGB_BASE   (RGB_B),
    .Y_BASE     (Y_B),
    .U_BASE     (U_B),
    .V_BASE     (V_B),
    .NUM_GROUPS (NG)
  ) dut (
    .Clock           (Clock),
    .Resetn          (Resetn),
    .Enable          (Enable),
    .SRAM_address    (SRAM_address),
    .SRAM_read_data  (SRAM_read_data),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n),
    .Done            (Done)
  );

  always #5 Clock = ~Clock;

  int checks = 0, errors = 0;
  int cyc = 0, en_edge = 0;
  int done_cnt = 0, done_at = 0, wr_count = 0, last_wr = -1;
  bit no_write = 0;
  int wa;

  logic [15:0] sram [int];
  logic [15:0] exp_wr [int];
  bit          written [int];
  logic [15:0] pipe1 = '0;
  logic [7:0]  pr [NPIX];
  logic [7:0]  pg [NPIX];
  logic [7:0]  pb [NPIX];

  always @(posedge Clock) cyc <= cyc + 1;

  always @(posedge Clock) begin
    pipe1          <= sram.exists(int'(SRAM_address)) ? sram[int'(SRAM_address)] : 16'h0;
    SRAM_read_data <= pipe1;
    if (Resetn === 1'b1 && SRAM_we_n === 1'b0) sram[int'(SRAM_address)] = SRAM_write_data;
  end

  function automatic logic [15:0] rd(input int a);
    return sram.exists(a) ? sram[a] : 16'h0;
  endfunction

  function automatic int clip8(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  function automatic logic [7:0] f_y(input int r, input int g, input int b);
    return 8'(clip8(((66 * r + 129 * g + 25 * b + 128) >>> 8) + 16));
  endfunction

  function automatic logic [7:0] f_u(input int r, input int g, input int b);
    return 8'(clip8(((-38 * r - 74 * g + 112 * b + 128) >>> 8) + 128));
  endfunction

  function automatic logic [7:0] f_v(input int r, input int g, input int b);
    return 8'(clip8(((112 * r - 94 * g - 18 * b + 128) >>> 8) + 128));
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic load_image(input int mode);
    int p;
    for (int i = 0; i < NPIX; i++) begin
      case (mode)
        0: begin pr[i] = 8'd0; pg[i] = 8'd0; pb[i] = 8'd0; end
        1: begin pr[i] = 8'd255; pg[i] = 8'd255; pb[i] = 8'd255; end
        2: begin pr[i] = (i == 0) ? 8'd255 : 8'd0; pg[i] = 8'd0; pb[i] = 8'd0; end
        3: begin pr[i] = 8'($urandom); pg[i] = 8'($urandom); pb[i] = 8'($urandom); end
        default: begin pr[i] = 8'(i); pg[i] = 8'(255 - i); pb[i] = 8'(i * 7); end
      endcase
    end
    for (int j = 0; j < NPIX / 2; j++) begin
      sram[RGB_B + 3 * j]     = {pr[2 * j], pg[2 * j]};
      sram[RGB_B + 3 * j + 1] = {pb[2 * j], pr[2 * j + 1]};
      sram[RGB_B + 3 * j + 2] = {pg[2 * j + 1], pb[2 * j + 1]};
    end
    exp_wr.delete();
    written.delete();
    for (int k = 0; k < NG; k++) begin
      logic [7:0] y [4];
      for (int q = 0; q < 4; q++) begin
        p = 4 * k + q;
        y[q] = f_y(pr[p], pg[p], pb[p]);
      end
      p = 4 * k;
      exp_wr[Y_B + 2 * k]     = {y[0], y[1]};
      exp_wr[Y_B + 2 * k + 1] = {y[2], y[3]};
      exp_wr[U_B + k] = {f_u(pr[p], pg[p], pb[p]), f_u(pr[p + 2], pg[p + 2], pb[p + 2])};
      exp_wr[V_B + k] = {f_v(pr[p], pg[p], pb[p]), f_v(pr[p + 2], pg[p + 2], pb[p + 2])};
      sram.delete(Y_B + 2 * k);
      sram.delete(Y_B + 2 * k + 1);
      sram.delete(U_B + k);
      sram.delete(V_B + k);
    end
  endtask

  always @(negedge Clock) begin
    if (Resetn === 1'b1) begin
      if (SRAM_we_n === 1'b0) begin
        wa = int'(SRAM_address);
        wr_count++;
        last_wr = wa;
        checks++;
        if (no_write) begin
          errors++;
          $display("FAIL write_after_reset addr=%0d data=%0h required=no write", wa, SRAM_write_data);
        end else if (!exp_wr.exists(wa)) begin
          errors++;
          $display("FAIL write_region addr=%0d required=inside Y/U/V image regions", wa);
        end else if (written.exists(wa)) begin
          errors++;
          $display("FAIL write_dup addr=%0d required=single write", wa);
        end else if (SRAM_write_data !== exp_wr[wa]) begin
          errors++;
          $display("FAIL write_data addr=%0d actual=%0h required=%0h", wa, SRAM_write_data, exp_wr[wa]);
        end
        written[wa] = 1'b1;
      end
      if (Done === 1'b1) begin
        done_cnt++;
        done_at = cyc - en_edge + 1;
      end
    end
  end

  task automatic start_job();
    done_cnt = 0;
    wr_count = 0;
    last_wr  = -1;
    @(negedge Clock);
    Enable = 1'b1;
    @(posedge Clock);
    #1;
    Enable  = 1'b0;
    en_edge = cyc;
  endtask

  task automatic run_job(input int mode, input int pulse_at);
    bit ok;
    load_image(mode);
    start_job();
    ok = 1'b0;
    for (int i = 1; i <= 12 * NG + 20; i++) begin
      Enable = (i == pulse_at);
      @(posedge Clock);
      #1;
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    Enable = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout mode=%0d actual=no Done required=Done", mode);
    end
    repeat (4) @(posedge Clock);
    #1;
    check("done_count", done_cnt, 1);
    check("done_cycle", done_at, 12 * NG + 1);
    check("write_count", wr_count, 4 * NG);
    check("last_write_addr", last_wr, V_B + NG - 1);
    check("words_written", written.num(), exp_wr.num());
  endtask

  initial begin
    Resetn = 1'b0;
    Enable = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_we_n", int'(SRAM_we_n), 1);
    check("rst_addr", int'(SRAM_address), 0);
    check("rst_wdata", int'(SRAM_write_data), 0);
    check("rst_done", int'(Done), 0);
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (2) @(posedge Clock);

    run_job(0, 0);
    check("zero_y", int'(rd(Y_B + 5)), 16'h1010);
    check("zero_u", int'(rd(U_B + NG - 1)), 16'h8080);
    check("zero_v", int'(rd(V_B)), 16'h8080);

    run_job(1, 0);
    check("white_y", int'(rd(Y_B + 7)), 16'hEBEB);
    check("white_u", int'(rd(U_B + 3)), 16'h8080);
    check("white_v", int'(rd(V_B + NG - 1)), 16'h8080);

    run_job(2, 0);
    check("model_red_y", int'(exp_wr[Y_B]), 16'h5210);
    check("model_red_u", int'(exp_wr[U_B]), 16'h5A80);
    check("model_red_v", int'(exp_wr[V_B]), 16'hF080);
    check("red_y", int'(rd(Y_B)), 16'h5210);
    check("red_y1", int'(rd(Y_B + 1)), 16'h1010);
    check("red_u", int'(rd(U_B)), 16'h5A80);
    check("red_v", int'(rd(V_B)), 16'hF080);

    run_job(3, 100);

    load_image(4);
    start_job();
    repeat (12 * 5 + 4) @(posedge Clock);
    #2;
    no_write = 1'b1;
    Resetn   = 1'b0;
    #1;
    check("abort_we_n", int'(SRAM_we_n), 1);
    check("abort_addr", int'(SRAM_address), 0);
    check("abort_wdata", int'(SRAM_write_data), 0);
    repeat (3) @(posedge Clock);
    #3;
    Resetn = 1'b1;
    repeat (12) @(posedge Clock);
    #1;
    check("abort_no_done", done_cnt, 0);
    no_write = 1'b0;
    run_job(4, 0);

    run_job(3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
